dma_spi: RTL and testbench
==========================

Name: dma_spi

Overview:
- SPI slave receiver for one 51-byte (408-bit) command frame sent by the MCU's DMA.
- Fully oversampled in the single system clock domain.
- Decodes the frame into the real-time command fields (system time, DDS frequency/step/rate, start time, pulse train parameters).
- Issues a write strobe to the real-time command register block (wcm), a time-update strobe to the synchronizer (master_start), and a reset request for the register block.

Parameters:
RST_LEN, 4, cycles RESET_WCW stays high after a reset-command frame
RESET_CMD, 8'hFF, TYPE_impulse value that marks a reset-command frame
TIMEOUT_CYC, 65535, idle clk cycles with CS low before frame abort (used only with the optional feature)

Ports:
clk  in  1  system clock; SCLK must not exceed clk/4
rst  in  1  reset, asynchronous, active-high
clk_en  in  1  clock enable; when 0 all state including synchronizers holds
MOSI  in  1  SPI data, asynchronous to clk
CS  in  1  SPI chip select, active low, asynchronous
SCLK  in  1  SPI clock, asynchronous; MOSI sampled on rising edge
TIME  out  64  system time field
SYS_TIME_UPDATE  out  1  one-cycle pulse: valid frame with TIME != 0
FREQ  out  48  DDS start frequency
FREQ_STEP  out  48  DDS frequency step
FREQ_RATE  out  32  DDS step rate
TIME_START  out  64  command start time
N_impulse  out  16  pulse count
TYPE_impulse  out  8  pulse train type
Interval_Ti  out  32  emission interval
Interval_Tp  out  32  receive interval
Tblank1  out  32  blank interval 1
Tblank2  out  32  blank interval 2
SPI_WR  out  1  one-cycle write strobe; fields valid
RESET_WCW  out  1  reset request for wcm, RST_LEN cycles

Behaviour:
- Reset: all outputs and internal state go to 0, including bit counter, shift register and pulse counters.
- Input synchronization:
  - MOSI, CS and SCLK each pass through a 2-FF synchronizer.
  - A third register provides edge detection.
- CS falling edge (synchronized): clear bit counter and shift register; frame active.
- SCLK rising edge while synchronized CS is low:
  - Shift the register left and insert synchronized MOSI at the LSB (MSB first).
  - Bit counter increments, saturating at 409.
- SCLK edges while CS is high are ignored.
- Frame layout, MSB first (bit 407 down to 0):
  - TIME[407:344], FREQ[343:296], FREQ_STEP[295:248], FREQ_RATE[247:216]
  - TIME_START[215:152], N_impulse[151:136], TYPE_impulse[135:128]
  - Interval_Ti[127:96], Interval_Tp[95:64], Tblank1[63:32], Tblank2[31:0]
- CS rising edge (synchronized), next cycle:
  - Count == 408 and TYPE field != RESET_CMD:
    - All field outputs load from the shift register.
    - SPI_WR pulses high for exactly 1 cycle, coincident with the new field values.
    - SYS_TIME_UPDATE pulses in the same cycle iff the TIME field != 0.
  - Count == 408 and TYPE field == RESET_CMD:
    - Fields are not updated; SPI_WR stays low.
    - RESET_WCW goes high for RST_LEN enabled cycles.
  - Count != 408 (short or long frame): discard; no strobe; outputs unchanged.
- Field outputs hold their value until the next valid frame.
- Simultaneous SCLK rise and CS rise in the same synchronized cycle: the bit is shifted first, then the end-of-frame check runs on the updated count.
- New CS fall while RESET_WCW is active: reception proceeds; RESET_WCW completes its count.
- clk_en low: no sampling, counting or pulse progress; pulses stretch across disabled cycles.
- Reset mid-frame: frame is lost; the next CS fall starts cleanly.
- Latency: SPI_WR asserts 4 clk cycles after the CS pin rises (2 sync + 1 edge + 1 load).

Optional Feature:
- Macro DMA_SPI_TIMEOUT_EN.
- Defined:
  - A counter runs while CS is low; any SCLK rising edge clears it.
  - Reaching TIMEOUT_CYC sets the bit counter to 409, so the frame is discarded at CS rise.
- Not defined: no timeout; a frame stays open until CS rises.

Decomposition:
- Package dma_spi_pkg:
  - FRAME_BITS = 408.
  - Per-field width and LSB-offset localparams.
  - Packed struct dma_cmd_t in frame order.
- Sub-module spi_sync_edge: 2-FF synchronizer plus rise/fall detect, one instance per input, with clk_en.

Test Plan:
- Reset: rst high 300 ns → all outputs 0, SPI_WR = 0.
- Valid frame, 50 MHz clk, 12.5 MHz SCLK, 408 bits:
  - Field values: TIME=1, FREQ=48'h280000000000, FREQ_STEP=48'h2cbd3f, FREQ_RATE=1, TIME_START=50000, N=10, TYPE=0, Ti=100, Tp=100, Tb1=10, Tb2=5.
  - Required response: exactly one SPI_WR pulse and one SYS_TIME_UPDATE pulse; all fields match.
- Same frame with TIME=0, TIME_START=24000 → SPI_WR pulse; SYS_TIME_UPDATE stays 0; TIME_START=24000.
- 407-bit frame, then a 409-bit frame → no SPI_WR; outputs keep the previous values.
- Valid frame with TYPE=8'hFF → RESET_WCW high for 4 cycles; SPI_WR 0; fields unchanged.
- clk_en = 0 during a whole frame → no strobe; 408 bits with clk_en = 1 afterwards → normal SPI_WR.

Source files
------------

// File: rtl/dma_spi_pkg.sv
// Shared frame geometry and command layout for the dma_spi SPI command receiver.
`timescale 1ns/1ps
package dma_spi_pkg;
  localparam int FRAME_BITS = 408;
  localparam int CNT_W      = 9;

  localparam int TIME_W   = 64;
  localparam int FREQ_W   = 48;
  localparam int STEP_W   = 48;
  localparam int RATE_W   = 32;
  localparam int TSTART_W = 64;
  localparam int N_W      = 16;
  localparam int TYPE_W   = 8;
  localparam int IVL_W    = 32;

  localparam int TIME_LSB   = 344;
  localparam int FREQ_LSB   = 296;
  localparam int STEP_LSB   = 248;
  localparam int RATE_LSB   = 216;
  localparam int TSTART_LSB = 152;
  localparam int N_LSB      = 136;
  localparam int TYPE_LSB   = 128;
  localparam int TI_LSB     = 96;
  localparam int TP_LSB     = 64;
  localparam int TB1_LSB    = 32;
  localparam int TB2_LSB    = 0;

  // First member is the first bit on the wire (frame bit 407).
  typedef struct packed {
    logic [TIME_W-1:0]   sys_time;
    logic [FREQ_W-1:0]   freq;
    logic [STEP_W-1:0]   freq_step;
    logic [RATE_W-1:0]   freq_rate;
    logic [TSTART_W-1:0] time_start;
    logic [N_W-1:0]      n_impulse;
    logic [TYPE_W-1:0]   type_impulse;
    logic [IVL_W-1:0]    interval_ti;
    logic [IVL_W-1:0]    interval_tp;
    logic [IVL_W-1:0]    tblank1;
    logic [IVL_W-1:0]    tblank2;
  } dma_cmd_t;

  function automatic logic is_reset_type(input dma_cmd_t c, input logic [TYPE_W-1:0] code);
    return c.type_impulse == code;
  endfunction
endpackage

// File: rtl/dma_spi_sync_edge.sv
// Two-flop synchronizer with a third edge-detect flop; all flops hold while clk_en is low.
`timescale 1ns/1ps
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else if (clk_en) begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
endmodule

// File: rtl/dma_spi.sv
// SPI slave receiver for the 408-bit real-time command frame, oversampled on clk.
// Optional build macro DMA_SPI_TIMEOUT_EN aborts a frame left idle with CS low.
`timescale 1ns/1ps
module dma_spi
  import dma_spi_pkg::*;
#(
  parameter int          RST_LEN     = 4,
  parameter logic [7:0]  RESET_CMD   = 8'hFF,
  parameter int          TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        MOSI,
  input  logic        CS,
  input  logic        SCLK,
  output logic [63:0] TIME,
  output logic        SYS_TIME_UPDATE,
  output logic [47:0] FREQ,
  output logic [47:0] FREQ_STEP,
  output logic [31:0] FREQ_RATE,
  output logic [63:0] TIME_START,
  output logic [15:0] N_impulse,
  output logic [7:0]  TYPE_impulse,
  output logic [31:0] Interval_Ti,
  output logic [31:0] Interval_Tp,
  output logic [31:0] Tblank1,
  output logic [31:0] Tblank2,
  output logic        SPI_WR,
  output logic        RESET_WCW
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  localparam int               RCNT_W   = $clog2(RST_LEN + 1);

  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall_unused;

  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  eof_p1;
  logic [RCNT_W-1:0]     rst_cnt;
  dma_cmd_t              cmd;

  spi_sync_edge u_mosi (.clk(clk), .rst(rst), .clk_en(clk_en), .din(MOSI),
                        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
  spi_sync_edge u_cs   (.clk(clk), .rst(rst), .clk_en(clk_en), .din(CS),
                        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge u_sclk (.clk(clk), .rst(rst), .clk_en(clk_en), .din(SCLK),
                        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused));

  assign cmd = shreg;

`ifdef DMA_SPI_TIMEOUT_EN
  logic [31:0] to_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg           <= '0;
      bit_cnt         <= '0;
      eof_p1          <= 1'b0;
      rst_cnt         <= '0;
      SPI_WR          <= 1'b0;
      SYS_TIME_UPDATE <= 1'b0;
      RESET_WCW       <= 1'b0;
      TIME            <= '0;
      FREQ            <= '0;
      FREQ_STEP       <= '0;
      FREQ_RATE       <= '0;
      TIME_START      <= '0;
      N_impulse       <= '0;
      TYPE_impulse    <= '0;
      Interval_Ti     <= '0;
      Interval_Tp     <= '0;
      Tblank1         <= '0;
      Tblank2         <= '0;
`ifdef DMA_SPI_TIMEOUT_EN
      to_cnt          <= '0;
`endif
    end else if (clk_en) begin
      SPI_WR          <= 1'b0;
      SYS_TIME_UPDATE <= 1'b0;

      // Stage p0: shift; a SCLK rise coincident with CS rise still lands its bit.
      if (cs_fall) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (sclk_rise && (!cs_lvl || cs_rise)) begin
        shreg <= {shreg[FRAME_BITS-2:0], mosi_lvl};
        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 9'd1;
      end

`ifdef DMA_SPI_TIMEOUT_EN
      if (cs_lvl || sclk_rise) begin
        to_cnt <= '0;
      end else if (to_cnt != 32'(TIMEOUT_CYC)) begin
        to_cnt <= to_cnt + 32'd1;
        if (to_cnt == 32'(TIMEOUT_CYC - 1)) bit_cnt <= CNT_MAX;
      end
`endif

      eof_p1 <= cs_rise;

      // Stage p1: end-of-frame decision on the count updated by the last shift.
      if (eof_p1 && bit_cnt == CNT_FULL) begin
        if (is_reset_type(cmd, RESET_CMD)) begin
          RESET_WCW <= 1'b1;
          rst_cnt   <= RCNT_W'(RST_LEN - 1);
        end else begin
          SPI_WR          <= 1'b1;
          SYS_TIME_UPDATE <= (cmd.sys_time != '0);
          TIME            <= cmd.sys_time;
          FREQ            <= cmd.freq;
          FREQ_STEP       <= cmd.freq_step;
          FREQ_RATE       <= cmd.freq_rate;
          TIME_START      <= cmd.time_start;
          N_impulse       <= cmd.n_impulse;
          TYPE_impulse    <= cmd.type_impulse;
          Interval_Ti     <= cmd.interval_ti;
          Interval_Tp     <= cmd.interval_tp;
          Tblank1         <= cmd.tblank1;
          Tblank2         <= cmd.tblank2;
        end
      end

      if (RESET_WCW && !(eof_p1 && bit_cnt == CNT_FULL && is_reset_type(cmd, RESET_CMD))) begin
        if (rst_cnt == '0) RESET_WCW <= 1'b0;
        else               rst_cnt   <= rst_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dma_spi.sv
// Scoreboard bench for dma_spi: frames are bit-banged on the SPI pins, expected commands queued.
`timescale 1ns/1ps
module tb_dma_spi;
  import dma_spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        MOSI = 1'b0;
  logic        CS = 1'b1;
  logic        SCLK = 1'b0;
  logic [63:0] TIME;
  logic        SYS_TIME_UPDATE;
  logic [47:0] FREQ, FREQ_STEP;
  logic [31:0] FREQ_RATE;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [7:0]  TYPE_impulse;
  logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
  logic        SPI_WR, RESET_WCW;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int stu_count = 0;
  int rwcw_cycles = 0;
  dma_cmd_t exp_q[$];

  dma_spi dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .MOSI(MOSI), .CS(CS), .SCLK(SCLK),
    .TIME(TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .FREQ(FREQ), .FREQ_STEP(FREQ_STEP),
    .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START), .N_impulse(N_impulse),
    .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
    .Tblank1(Tblank1), .Tblank2(Tblank2), .SPI_WR(SPI_WR), .RESET_WCW(RESET_WCW)
  );

  always #10 clk = ~clk;

  function automatic dma_cmd_t dut_fields();
    dma_cmd_t f;
    f.sys_time     = TIME;
    f.freq         = FREQ;
    f.freq_step    = FREQ_STEP;
    f.freq_rate    = FREQ_RATE;
    f.time_start   = TIME_START;
    f.n_impulse    = N_impulse;
    f.type_impulse = TYPE_impulse;
    f.interval_ti  = Interval_Ti;
    f.interval_tp  = Interval_Tp;
    f.tblank1      = Tblank1;
    f.tblank2      = Tblank2;
    return f;
  endfunction

  function automatic dma_cmd_t make_cmd(input logic [63:0] t, input logic [63:0] ts,
                                        input logic [7:0] ty, input logic [15:0] n);
    dma_cmd_t c;
    c.sys_time     = t;
    c.freq         = 48'h280000000000;
    c.freq_step    = 48'h2cbd3f;
    c.freq_rate    = 32'd1;
    c.time_start   = ts;
    c.n_impulse    = n;
    c.type_impulse = ty;
    c.interval_ti  = 32'd100;
    c.interval_tp  = 32'd100;
    c.tblank1      = 32'd10;
    c.tblank2      = 32'd5;
    return c;
  endfunction

  // Output monitor: every write strobe is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && clk_en) begin
      if (RESET_WCW) rwcw_cycles++;
      if (SYS_TIME_UPDATE) stu_count++;
      if (SPI_WR) begin
        dma_cmd_t e;
        wr_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_spi_wr: strobe seen with no frame expected");
        end else begin
          e = exp_q.pop_front();
          if (dut_fields() !== e) begin
            errors++;
            $display("FAIL fields: got %h expected %h", dut_fields(), e);
          end
          checks++;
          if (SYS_TIME_UPDATE !== (e.sys_time != 64'd0)) begin
            errors++;
            $display("FAIL sys_time_update: got %b expected %b", SYS_TIME_UPDATE, e.sys_time != 64'd0);
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [407:0] data, input int nbits);
    @(posedge clk);
    #5;
    CS = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 408) ? data[407 - i] : 1'b0;
      #40 SCLK = 1'b1;
      #40 SCLK = 1'b0;
    end
    #60 CS = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #300;
    checks++;
    if (SPI_WR !== 1'b0) begin errors++; $display("FAIL reset_spi_wr: got %b expected 0", SPI_WR); end
    checks++;
    if (SYS_TIME_UPDATE !== 1'b0) begin errors++; $display("FAIL reset_stu: got %b expected 0", SYS_TIME_UPDATE); end
    checks++;
    if (RESET_WCW !== 1'b0) begin errors++; $display("FAIL reset_wcw: got %b expected 0", RESET_WCW); end
    checks++;
    if (dut_fields() !== '0) begin errors++; $display("FAIL reset_fields: got %h expected 0", dut_fields()); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_valid_frame();
    dma_cmd_t c = make_cmd(64'd1, 64'd50000, 8'd0, 16'd10);
    int wr0 = wr_count, stu0 = stu_count;
    exp_q.push_back(c);
    send_frame(c, 408);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL valid_pending: got %0d queued expected 0", exp_q.size()); end
    checks++;
    if (wr_count - wr0 != 1) begin errors++; $display("FAIL valid_wr_count: got %0d expected 1", wr_count - wr0); end
    checks++;
    if (stu_count - stu0 != 1) begin errors++; $display("FAIL valid_stu_count: got %0d expected 1", stu_count - stu0); end
    checks++;
    if (TIME !== 64'd1) begin errors++; $display("FAIL valid_time: got %0d expected 1", TIME); end
  endtask

  task automatic test_time_zero();
    dma_cmd_t c = make_cmd(64'd0, 64'd24000, 8'd0, 16'd10);
    int wr0 = wr_count, stu0 = stu_count;
    exp_q.push_back(c);
    send_frame(c, 408);
    checks++;
    if (wr_count - wr0 != 1) begin errors++; $display("FAIL tz_wr_count: got %0d expected 1", wr_count - wr0); end
    checks++;
    if (stu_count != stu0) begin errors++; $display("FAIL tz_stu_count: got %0d expected 0", stu_count - stu0); end
    checks++;
    if (TIME_START !== 64'd24000) begin errors++; $display("FAIL tz_time_start: got %0d expected 24000", TIME_START); end
  endtask

  task automatic test_bad_length();
    dma_cmd_t keep = make_cmd(64'd0, 64'd24000, 8'd0, 16'd10);
    dma_cmd_t d = make_cmd(64'h1234, 64'd777, 8'd3, 16'd99);
    int wr0 = wr_count, rw0 = rwcw_cycles;
    send_frame(d, 407);
    checks++;
    if (wr_count != wr0) begin errors++; $display("FAIL short_wr_count: got %0d expected 0", wr_count - wr0); end
    send_frame(d, 409);
    checks++;
    if (wr_count != wr0) begin errors++; $display("FAIL long_wr_count: got %0d expected 0", wr_count - wr0); end
    checks++;
    if (dut_fields() !== keep) begin errors++; $display("FAIL badlen_fields: got %h expected %h", dut_fields(), keep); end
    checks++;
    if (rwcw_cycles != rw0) begin errors++; $display("FAIL badlen_rwcw: got %0d expected 0", rwcw_cycles - rw0); end
  endtask

  task automatic test_reset_cmd();
    dma_cmd_t keep = make_cmd(64'd0, 64'd24000, 8'd0, 16'd10);
    dma_cmd_t r = make_cmd(64'd5, 64'd1, 8'hFF, 16'd7);
    int wr0 = wr_count, rw0 = rwcw_cycles;
    send_frame(r, 408);
    checks++;
    if (rwcw_cycles - rw0 != 4) begin errors++; $display("FAIL rwcw_cycles: got %0d expected 4", rwcw_cycles - rw0); end
    checks++;
    if (wr_count != wr0) begin errors++; $display("FAIL rcmd_wr_count: got %0d expected 0", wr_count - wr0); end
    checks++;
    if (dut_fields() !== keep) begin errors++; $display("FAIL rcmd_fields: got %h expected %h", dut_fields(), keep); end
    checks++;
    if (RESET_WCW !== 1'b0) begin errors++; $display("FAIL rwcw_end: got %b expected 0", RESET_WCW); end
  endtask

  task automatic test_clk_en();
    dma_cmd_t keep = make_cmd(64'd0, 64'd24000, 8'd0, 16'd10);
    dma_cmd_t c = make_cmd(64'd42, 64'd31337, 8'd2, 16'd4);
    int wr0 = wr_count;
    @(posedge clk);
    #5 clk_en = 1'b0;
    send_frame(c, 408);
    @(posedge clk);
    #5 clk_en = 1'b1;
    repeat (10) @(posedge clk);
    checks++;
    if (wr_count != wr0) begin errors++; $display("FAIL clken_wr_count: got %0d expected 0", wr_count - wr0); end
    checks++;
    if (dut_fields() !== keep) begin errors++; $display("FAIL clken_fields: got %h expected %h", dut_fields(), keep); end
    exp_q.push_back(c);
    send_frame(c, 408);
    checks++;
    if (wr_count - wr0 != 1) begin errors++; $display("FAIL clken_resume_wr: got %0d expected 1", wr_count - wr0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL clken_pending: got %0d queued expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_time_zero();
    test_bad_length();
    test_reset_cmd();
    test_clk_en();
    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
